// File: rtl/atm_txn_sequencer.sv
// atm_txn_sequencer: customer-side initiator that walks one transaction through the ATM
// controller (authentication, menu, operation) and returns balance/status on a response handshake.
module atm_txn_sequencer #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_acc,
   input  logic [15:0] req_pin,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_amount,
   input  logic [15:0] req_new_pin,
   input  logic        req_lang,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [1:0]  rsp_status,
   output logic [31:0] rsp_balance,
   output logic [3:0]  atm_acc_num,
   output logic [15:0] atm_pin,
   output logic [2:0]  atm_operation,
   output logic [31:0] atm_amount,
   output logic [15:0] atm_new_pin,
   output logic        atm_language,
   input  logic [2:0]  atm_state,
   input  logic [31:0] atm_balance,
   input  logic        atm_success,
   output logic [2:0]  dbg_state
);
   // Both handshakes: a transfer occurs on a rising clk edge where valid && ready are both 1;
   // once valid is raised it stays high with its payload unchanged until that transfer.

   localparam int          CW         = $clog2(TIMEOUT + 1);
   localparam logic [3:0]  IDLE_ACC   = 4'hF;
   localparam logic [2:0]  ST_WAITING = 3'd1;
   localparam logic [2:0]  ST_AUTH    = 3'd2;
   localparam logic [2:0]  ST_MENU    = 3'd3;
   localparam logic [2:0]  OP_NONE    = 3'd0;
   localparam logic [1:0]  RS_OK      = 2'd0;
   localparam logic [1:0]  RS_AUTH    = 2'd1;
   localparam logic [1:0]  RS_OPFAIL  = 2'd2;
   localparam logic [1:0]  RS_TIMEOUT = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE, S_AUTH_WAIT, S_MENU_WAIT, S_OP_WAIT, S_DONE_WAIT, S_RESP
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    op_q;
   logic          timed_out;
   logic          to_resp;
   logic [1:0]    resp_code;

   assign timed_out = (cnt == CW'(TIMEOUT - 1));
   assign dbg_state = state;

   // Every path into S_RESP (invalid op, auth failure, completion, timeout) is decided here;
   // a matching exit condition always takes priority over the timeout cycle.
   always_comb begin
      to_resp   = 1'b0;
      resp_code = RS_OK;
      case (state)
         S_IDLE: begin
            if (req_ready && req_valid && !req_op[2]) begin
               to_resp   = 1'b1;
               resp_code = RS_OPFAIL;
            end
         end
         S_AUTH_WAIT: begin
            if (atm_state != ST_AUTH && timed_out) begin
               to_resp   = 1'b1;
               resp_code = RS_TIMEOUT;
            end
         end
         S_MENU_WAIT: begin
            if (atm_state == ST_WAITING) begin
               to_resp   = 1'b1;
               resp_code = RS_AUTH;
            end else if (atm_state != ST_MENU && timed_out) begin
               to_resp   = 1'b1;
               resp_code = RS_TIMEOUT;
            end
         end
         S_OP_WAIT: begin
            if (atm_state != op_q && timed_out) begin
               to_resp   = 1'b1;
               resp_code = RS_TIMEOUT;
            end
         end
         S_DONE_WAIT: begin
            if (atm_state == ST_WAITING) begin
               to_resp   = 1'b1;
               resp_code = atm_success ? RS_OK : RS_OPFAIL;
            end else if (timed_out) begin
               to_resp   = 1'b1;
               resp_code = RS_TIMEOUT;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= S_IDLE;
         cnt           <= '0;
         op_q          <= OP_NONE;
         req_ready     <= 1'b1;
         rsp_valid     <= 1'b0;
         rsp_status    <= RS_OK;
         rsp_balance   <= '0;
         atm_acc_num   <= IDLE_ACC;
         atm_pin       <= '0;
         atm_operation <= OP_NONE;
         atm_amount    <= '0;
         atm_new_pin   <= '0;
         atm_language  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               // req_ready re-arms one cycle after a response, giving the bubble cycle.
               if (!req_ready) begin
                  req_ready <= 1'b1;
               end else if (req_valid) begin
                  req_ready     <= 1'b0;
                  state         <= S_AUTH_WAIT;
                  cnt           <= '0;
                  op_q          <= req_op;
                  rsp_balance   <= '0;
                  atm_acc_num   <= req_acc;
                  atm_pin       <= req_pin;
                  atm_operation <= OP_NONE;
                  atm_amount    <= req_amount;
                  atm_new_pin   <= req_new_pin;
                  atm_language  <= req_lang;
               end
            end
            S_AUTH_WAIT: begin
               if (atm_state == ST_AUTH) begin
                  state <= S_MENU_WAIT;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_MENU_WAIT: begin
               if (atm_state == ST_MENU) begin
                  atm_operation <= op_q;
                  state         <= S_OP_WAIT;
                  cnt           <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_OP_WAIT: begin
               if (atm_state == op_q) begin
                  state         <= S_DONE_WAIT;
                  cnt           <= '0;
                  atm_acc_num   <= IDLE_ACC;
                  atm_pin       <= '0;
                  atm_operation <= OP_NONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_DONE_WAIT: begin
               if (atm_state == ST_WAITING) rsp_balance <= atm_balance;
               else                         cnt <= cnt + CW'(1);
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase

         if (to_resp) begin
            state         <= S_RESP;
            rsp_valid     <= 1'b1;
            rsp_status    <= resp_code;
            cnt           <= '0;
            atm_acc_num   <= IDLE_ACC;
            atm_pin       <= '0;
            atm_operation <= OP_NONE;
            atm_amount    <= '0;
            atm_new_pin   <= '0;
            atm_language  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_atm_txn_sequencer.sv
// tb_atm_txn_sequencer: drives directed and random transactions through the sequencer against
// a stand-in ATM controller and compares responses with a transaction-level account model.
module tb_atm_txn_sequencer;

   localparam int          TIMEOUT    = 64;
   localparam logic [3:0]  IDLE_ACC   = 4'hF;
   localparam logic [2:0]  ST_WAITING = 3'd1;
   localparam logic [2:0]  ST_AUTH    = 3'd2;
   localparam logic [2:0]  ST_MENU    = 3'd3;
   localparam logic [2:0]  OP_BAL     = 3'd4;
   localparam logic [2:0]  OP_WD      = 3'd5;
   localparam logic [2:0]  OP_DEP     = 3'd6;
   localparam logic [2:0]  OP_PIN     = 3'd7;
   localparam logic [1:0]  RS_OK      = 2'd0;
   localparam logic [1:0]  RS_AUTH    = 2'd1;
   localparam logic [1:0]  RS_OPFAIL  = 2'd2;
   localparam logic [1:0]  RS_TIMEOUT = 2'd3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_acc = '0;
   logic [15:0] req_pin = '0;
   logic [2:0]  req_op = '0;
   logic [31:0] req_amount = '0;
   logic [15:0] req_new_pin = '0;
   logic        req_lang = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [1:0]  rsp_status;
   logic [31:0] rsp_balance;
   logic [3:0]  atm_acc_num;
   logic [15:0] atm_pin;
   logic [2:0]  atm_operation;
   logic [31:0] atm_amount;
   logic [15:0] atm_new_pin;
   logic        atm_language;
   logic [2:0]  atm_state;
   logic [31:0] atm_balance;
   logic        atm_success;
   logic [2:0]  dbg_state;

   int n_total = 0;
   int n_bad   = 0;
   logic [34:0] exp_q[$];   // {check_balance, status, balance}
   logic [15:0] r_pin [16];
   logic [31:0] r_bal [16];

   atm_txn_sequencer #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_acc(req_acc), .req_pin(req_pin),
      .req_op(req_op), .req_amount(req_amount), .req_new_pin(req_new_pin), .req_lang(req_lang),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
      .rsp_balance(rsp_balance),
      .atm_acc_num(atm_acc_num), .atm_pin(atm_pin), .atm_operation(atm_operation),
      .atm_amount(atm_amount), .atm_new_pin(atm_new_pin), .atm_language(atm_language),
      .atm_state(atm_state), .atm_balance(atm_balance), .atm_success(atm_success),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Stand-in controller: advances one state per cycle; accounts 1..3 exist in its database.
   logic [2:0]  c_state;
   logic [3:0]  c_acc;
   logic [31:0] c_bal_out;
   logic        c_succ;
   logic [15:0] ctl_pin [16];
   logic [31:0] ctl_bal [16];
   assign atm_state   = c_state;
   assign atm_balance = c_bal_out;
   assign atm_success = c_succ;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         c_state   <= ST_WAITING;
         c_acc     <= 4'd0;
         c_bal_out <= 32'd0;
         c_succ    <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            ctl_pin[i] <= (i == 1) ? 16'd1234 : (i == 2) ? 16'd4321 : (i == 3) ? 16'h0BEE : 16'd0;
            ctl_bal[i] <= (i == 1) ? 32'd500 : (i == 2) ? 32'd1000 : (i == 3) ? 32'd50 : 32'd0;
         end
      end else begin
         case (c_state)
            ST_WAITING: begin
               if (atm_acc_num >= 4'd1 && atm_acc_num <= 4'd3) begin
                  c_state <= ST_AUTH;
                  c_acc   <= atm_acc_num;
               end
            end
            ST_AUTH: c_state <= (atm_pin == ctl_pin[c_acc]) ? ST_MENU : ST_WAITING;
            ST_MENU: if (atm_operation[2]) c_state <= atm_operation;
            OP_BAL: begin
               c_bal_out <= ctl_bal[c_acc];
               c_succ    <= 1'b1;
               c_state   <= ST_WAITING;
            end
            OP_WD: begin
               if (atm_amount <= ctl_bal[c_acc]) begin
                  ctl_bal[c_acc] <= ctl_bal[c_acc] - atm_amount;
                  c_bal_out      <= ctl_bal[c_acc] - atm_amount;
                  c_succ         <= 1'b1;
               end else begin
                  c_bal_out <= ctl_bal[c_acc];
                  c_succ    <= 1'b0;
               end
               c_state <= ST_WAITING;
            end
            OP_DEP: begin
               ctl_bal[c_acc] <= ctl_bal[c_acc] + atm_amount;
               c_bal_out      <= ctl_bal[c_acc] + atm_amount;
               c_succ         <= 1'b1;
               c_state        <= ST_WAITING;
            end
            OP_PIN: begin
               ctl_pin[c_acc] <= atm_new_pin;
               c_bal_out      <= ctl_bal[c_acc];
               c_succ         <= 1'b1;
               c_state        <= ST_WAITING;
            end
            default: c_state <= ST_WAITING;
         endcase
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic ref_reset();
      for (int i = 0; i < 16; i++) begin
         r_pin[i] = 16'd0;
         r_bal[i] = 32'd0;
      end
      r_pin[1] = 16'd1234; r_bal[1] = 32'd500;
      r_pin[2] = 16'd4321; r_bal[2] = 32'd1000;
      r_pin[3] = 16'h0BEE; r_bal[3] = 32'd50;
   endtask

   // Transaction-level outcome: invalid op, unknown account, wrong PIN, then the operation itself.
   task automatic model_txn(input logic [3:0] acc, input logic [15:0] pin, input logic [2:0] op,
                            input logic [31:0] amt, input logic [15:0] npin);
      logic [1:0]  st;
      logic [31:0] bal;
      logic        chk;
      st = RS_OK; bal = 32'd0; chk = 1'b0;
      if (op < 3'd4) st = RS_OPFAIL;
      else if (acc < 4'd1 || acc > 4'd3) st = RS_TIMEOUT;
      else if (pin != r_pin[acc]) st = RS_AUTH;
      else begin
         chk = 1'b1;
         if (op == OP_WD) begin
            if (amt <= r_bal[acc]) r_bal[acc] = r_bal[acc] - amt;
            else st = RS_OPFAIL;
         end else if (op == OP_DEP) begin
            r_bal[acc] = r_bal[acc] + amt;
         end else if (op == OP_PIN) begin
            r_pin[acc] = npin;
         end
         bal = r_bal[acc];
      end
      exp_q.push_back({chk, st, bal});
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_req_ready"}, 64'(req_ready), 64'(1));
      check_eq({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
      check_eq({tag, "_rsp_status"}, 64'(rsp_status), 64'(0));
      check_eq({tag, "_rsp_balance"}, 64'(rsp_balance), 64'(0));
      check_eq({tag, "_acc"}, 64'(atm_acc_num), 64'(IDLE_ACC));
      check_eq({tag, "_pin"}, 64'(atm_pin), 64'(0));
      check_eq({tag, "_op"}, 64'(atm_operation), 64'(0));
      check_eq({tag, "_amount"}, 64'(atm_amount), 64'(0));
      check_eq({tag, "_new_pin"}, 64'(atm_new_pin), 64'(0));
      check_eq({tag, "_lang"}, 64'(atm_language), 64'(0));
      check_eq({tag, "_state"}, 64'(dbg_state), 64'(0));
   endtask

   // Called at a negedge; returns at the first negedge after the accepting edge.
   task automatic send_req(input logic [3:0] acc, input logic [15:0] pin, input logic [2:0] op,
                           input logic [31:0] amt, input logic [15:0] npin, input logic lang);
      int k;
      req_acc = acc; req_pin = pin; req_op = op;
      req_amount = amt; req_new_pin = npin; req_lang = lang;
      req_valid = 1'b1;
      k = 0;
      while (!req_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      check_eq("accept_ready", 64'(req_ready), 64'(1));
      model_txn(acc, pin, op, amt, npin);
      @(negedge clk);
      req_valid = 1'b0;
      check_eq("ready_low_after_accept", 64'(req_ready), 64'(0));
      if (op[2]) begin
         check_eq("drv_acc", 64'(atm_acc_num), 64'(acc));
         check_eq("drv_pin", 64'(atm_pin), 64'(pin));
         check_eq("drv_op_none", 64'(atm_operation), 64'(0));
         check_eq("drv_amount", 64'(atm_amount), 64'(amt));
         check_eq("drv_new_pin", 64'(atm_new_pin), 64'(npin));
         check_eq("drv_lang", 64'(atm_language), 64'(lang));
      end else begin
         check_eq("badop_acc", 64'(atm_acc_num), 64'(IDLE_ACC));
      end
   endtask

   // Latency is the number of clock edges from acceptance to rsp_valid.
   task automatic get_rsp(input int dly, output int lat);
      logic [34:0] e;
      int k;
      k = 1;
      while (!rsp_valid && k < 200) begin
         @(negedge clk);
         k++;
      end
      lat = k - 1;
      check_eq("rsp_valid", 64'(rsp_valid), 64'(1));
      check_eq("resp_idle_acc", 64'(atm_acc_num), 64'(IDLE_ACC));
      check_eq("resp_idle_op", 64'(atm_operation), 64'(0));
      check_eq("resp_idle_pin", 64'(atm_pin), 64'(0));
      for (int i = 0; i < dly; i++) begin
         @(negedge clk);
         check_eq("rsp_hold", 64'(rsp_valid), 64'(1));
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 35'h0;
      check_eq("rsp_status", 64'(rsp_status), 64'(e[33:32]));
      if (e[34]) check_eq("rsp_balance", 64'(rsp_balance), 64'(e[31:0]));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check_eq("rsp_drop", 64'(rsp_valid), 64'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int          lat;
      int          k;
      logic [34:0] e;
      logic [3:0]  a;
      logic [15:0] p;
      logic [2:0]  o;
      ref_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b1;
      @(negedge clk);

      send_req(4'd1, 16'd1234, OP_BAL, 32'd0, 16'd0, 1'b0);
      get_rsp(0, lat);
      check_eq("balance_latency", 64'(lat), 64'(6));
      send_req(4'd1, 16'd1234, OP_WD, 32'd200, 16'd0, 1'b1);
      get_rsp(2, lat);
      send_req(4'd1, 16'd1234, OP_WD, 32'd1000, 16'd0, 1'b0);
      get_rsp(1, lat);
      send_req(4'd1, 16'h1111, OP_BAL, 32'd0, 16'd0, 1'b0);
      get_rsp(0, lat);
      send_req(4'hE, 16'd1234, OP_BAL, 32'd0, 16'd0, 1'b0);
      get_rsp(0, lat);
      check_eq("timeout_latency", 64'(lat), 64'(TIMEOUT));
      send_req(4'd3, 16'h0BEE, 3'd2, 32'd5, 16'd0, 1'b0);
      get_rsp(1, lat);

      // Response held while the next request waits.
      send_req(4'd2, 16'd4321, OP_BAL, 32'd0, 16'd0, 1'b1);
      k = 1;
      while (!rsp_valid && k < 200) begin
         @(negedge clk);
         k++;
      end
      check_eq("b2b_first_valid", 64'(rsp_valid), 64'(1));
      e = exp_q[0];
      req_acc = 4'd2; req_pin = 16'd4321; req_op = OP_DEP;
      req_amount = 32'd25; req_new_pin = 16'd0; req_lang = 1'b0;
      req_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_eq("b2b_hold_valid", 64'(rsp_valid), 64'(1));
         check_eq("b2b_hold_status", 64'(rsp_status), 64'(e[33:32]));
         check_eq("b2b_hold_balance", 64'(rsp_balance), 64'(e[31:0]));
         check_eq("b2b_req_ready", 64'(req_ready), 64'(0));
      end
      e = exp_q.pop_front();
      check_eq("b2b_status", 64'(rsp_status), 64'(e[33:32]));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check_eq("b2b_bubble", 64'(req_ready), 64'(0));
      k = 1;
      while (!req_ready && k < 10) begin
         @(negedge clk);
         k++;
      end
      check_eq("b2b_gap", 64'(k), 64'(2));
      send_req(4'd2, 16'd4321, OP_DEP, 32'd25, 16'd0, 1'b0);
      get_rsp(0, lat);

      // Reset while the operation is being requested.
      req_acc = 4'd2; req_pin = 16'd4321; req_op = OP_WD;
      req_amount = 32'd100; req_new_pin = 16'd0; req_lang = 1'b1;
      req_valid = 1'b1;
      k = 0;
      while (!req_ready && k < 10) begin
         @(negedge clk);
         k++;
      end
      check_eq("rst_accept", 64'(req_ready), 64'(1));
      @(negedge clk);
      req_valid = 1'b0;
      k = 0;
      while (atm_operation == 3'd0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check_eq("rst_op_driven", 64'(atm_operation), 64'(OP_WD));
      rst = 1'b0;
      #1;
      check_reset_vals("rst_mid");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("rst_no_rsp", 64'(rsp_valid), 64'(0));
         check_eq("rst_hold_acc", 64'(atm_acc_num), 64'(IDLE_ACC));
      end
      ref_reset();
      rst = 1'b1;
      @(negedge clk);
      send_req(4'd2, 16'd4321, OP_BAL, 32'd0, 16'd0, 1'b0);
      get_rsp(1, lat);
      check_eq("post_rst_latency", 64'(lat), 64'(6));

      for (int t = 0; t < 40; t++) begin
         a = ($urandom_range(0, 9) == 0) ? 4'hE : 4'($urandom_range(1, 3));
         p = ($urandom_range(0, 4) != 0) ? r_pin[a] : 16'($urandom_range(0, 65535));
         o = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
         send_req(a, p, o, 32'($urandom_range(0, 1200)), 16'($urandom_range(1, 65535)),
                  1'($urandom_range(0, 1)));
         get_rsp($urandom_range(0, 3), lat);
         if (o[2] && a == 4'hE) check_eq("rand_timeout_latency", 64'(lat), 64'(TIMEOUT));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
